// File: rtl/kamacore_pkg.sv
// kamacore_pkg
// Shared widths and types for the writeback path of the kamacore pipeline.
//   CPU_WIDTH       : datapath width of a result word
//   REG_ADDR_WIDTH  : register-file address width (x0 is the hardwired zero)
//   cpu_word_t      : one result word
//   reg_addr_t      : one register-file address
//   wb_stage_t      : contents of the registered writeback stage
package kamacore_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef logic [CPU_WIDTH-1:0]      cpu_word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rdA;
        cpu_word_t data;
    } wb_stage_t;

    // Writes to x0 are architecturally discarded.
    function automatic logic isZeroReg(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/kamacore_forwarding_if.sv
// kamacore_forwarding_if
// Bundle that exposes the committed writeback to the forwarding network.
//   we            : a register-file write is happening this cycle
//   a             : destination register of that write
//   data_original : data being written
// Modports: source (the writeback stage drives it), sink (forwarding muxes).
interface kamacore_forwarding_if;

    logic                          we;
    kamacore_pkg::reg_addr_t       a;
    kamacore_pkg::cpu_word_t       data_original;

    modport source (output we, output a, output data_original);
    modport sink   (input  we, input  a, input  data_original);

endinterface

// File: rtl/kamacore_rr_arbiter.sv
// kamacore_rr_arbiter
// Round-robin arbiter with a registered priority pointer.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset, puts requester 0 at top priority
//   req     : N request lines
//   grant   : one-hot grant, combinational from req and the pointer
//   advance : a grant was consumed this cycle; move the pointer past the winner
module kamacore_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] winIdx;
    logic [N-1:0]  shiftedReq;
    int            idx;

    // Walk the requesters from the farthest offset back to the pointer, so
    // the last hit written is the one closest to the pointer and wins.
    always_comb begin
        grant      = '0;
        winIdx     = '0;
        idx        = 0;
        shiftedReq = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            shiftedReq = req >> idx;
            if (shiftedReq[0]) begin
                grant  = N'(1) << idx;
                winIdx = PW'(idx);
            end
        end
    end

    // The pointer moves only when a grant is actually taken.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(winIdx) == N - 1) ? '0 : winIdx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/kamacore_wb_merge.sv
// kamacore_wb_merge
// Merges several writeback result channels into the single register-file
// write port, one result per cycle, with round-robin fairness.
//   clk, rst            : clock and asynchronous active-low reset
//   src_valid/src_ready : per-source handshake; ready marks the granted source
//   src_rd_a, src_data  : per-source destination register and result
//   flush               : kills the registered result in the current cycle
//   writeback_rd_*      : register-file write port (one cycle after transfer)
//   forwarding          : mirror of the writeback port for bypassing
//   retire_count        : saturating count of committed non-x0 writes
module kamacore_wb_merge
    import kamacore_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_SRC-1:0]                      src_valid,
    output logic [NUM_SRC-1:0]                      src_ready,
    input  logic [NUM_SRC-1:0][REG_ADDR_WIDTH-1:0]  src_rd_a,
    input  logic [NUM_SRC-1:0][CPU_WIDTH-1:0]       src_data,
    input  logic                                    flush,
    output logic                                    writeback_rd_we,
    output logic [REG_ADDR_WIDTH-1:0]               writeback_rd_a,
    output logic [CPU_WIDTH-1:0]                    writeback_rd_data,
    kamacore_forwarding_if.source                   forwarding,
    output logic [CNT_WIDTH-1:0]                    retire_count
);

    logic [NUM_SRC-1:0]   grant;
    logic [NUM_SRC-1:0]   readyRaw;
    logic                 transfer;
    reg_addr_t            selRdA;
    cpu_word_t            selData;
    wb_stage_t            wb_q;
    wb_stage_t            wb_d;
    logic [CNT_WIDTH-1:0] retire_q;
    logic [CNT_WIDTH-1:0] retire_d;

    kamacore_rr_arbiter #(
        .N(NUM_SRC)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .grant   (grant),
        .advance (transfer)
    );

    // A single source is a plain pipeline register and is always ready;
    // otherwise only the arbiter winner is. Nothing is ready during reset.
    always_comb begin
        readyRaw  = (NUM_SRC == 1) ? '1 : grant;
        src_ready = rst ? readyRaw : '0;
        transfer  = |(src_valid & src_ready);
    end

    // Ready is one-hot, so a priority-free OR-style select is enough.
    always_comb begin
        selRdA  = '0;
        selData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_ready[i]) begin
                selRdA  = src_rd_a[i];
                selData = src_data[i];
            end
        end
    end

    // The output stage never stalls; x0 results are accepted but never write.
    always_comb begin
        wb_d = '0;
        if (transfer) begin
            wb_d.valid = !isZeroReg(selRdA);
            wb_d.rdA   = selRdA;
            wb_d.data  = selData;
        end
    end

    // Count commits after flush has been applied, holding at all-ones.
    always_comb begin
        retire_d = retire_q;
        if (writeback_rd_we && (retire_q != '1)) begin
            retire_d = retire_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q     <= '0;
            retire_q <= '0;
        end else begin
            wb_q     <= wb_d;
            retire_q <= retire_d;
        end
    end

    assign writeback_rd_we          = wb_q.valid & ~flush;
    assign writeback_rd_a           = wb_q.rdA;
    assign writeback_rd_data        = wb_q.data;
    assign retire_count             = retire_q;

    assign forwarding.we            = writeback_rd_we;
    assign forwarding.a             = writeback_rd_a;
    assign forwarding.data_original = writeback_rd_data;

endmodule
